// File: rtl/weight_fetch_master_if.sv
`default_nettype none
// ============================================================================
// Module   : weight_fetch_master_if
// Purpose  : Command, Avalon-MM read master and weight stream signal bundle
// Revision : 1.0  initial release
// ============================================================================
interface weight_fetch_master_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [12:0]       start_index;
    logic [13:0]       word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic [31:0]       weight_data;
    logic              weight_valid;
    logic              weight_ready;

    modport master (
        input  start, start_index, word_count,
        output busy, done,
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output weight_data, weight_valid,
        input  weight_ready
    );

    modport slave (
        output start, start_index, word_count,
        input  busy, done,
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  weight_data, weight_valid,
        output weight_ready
    );
endinterface
`default_nettype wire

// File: rtl/weight_fetch_master.sv
`default_nettype none
// ============================================================================
// Module   : weight_fetch_master
// Purpose  : Pipelined Avalon-MM read master streaming weights through a FIFO
// Revision : 1.0  initial release
// ============================================================================
module weight_fetch_master #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                MAX_PENDING = 4,
    parameter int                FIFO_DEPTH  = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    weight_fetch_master_if.master bus
);
    localparam int          c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int          c_CNT_W    = c_PTR_W + 1;
    localparam logic [3:0]  c_MAX_PEND = 4'(MAX_PENDING);

    localparam logic [1:0]  c_IDLE  = 2'd0;
    localparam logic [1:0]  c_ISSUE = 2'd1;
    localparam logic [1:0]  c_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [12:0]        r_index;
    logic [13:0]        r_remaining;
    logic [3:0]         r_pending;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_credit_ok;
    logic               w_launch;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_offset;

    // Outstanding reads plus buffered words never exceed the FIFO, so a push always has room.
    assign w_credit_ok = (32'(r_pending) + 32'(r_count)) < 32'(FIFO_DEPTH);
    assign w_launch    = (r_state == c_ISSUE) && (r_remaining != 14'd0) &&
                         (r_pending < c_MAX_PEND) && w_credit_ok;
    assign w_accept    = w_launch && !bus.avm_waitrequest;
    assign w_push      = bus.avm_readdatavalid && (r_pending != 4'd0);
    assign w_pop       = (r_count != '0) && bus.weight_ready;
    assign w_offset    = ADDR_W'({r_index, 2'b00});

    assign bus.avm_read     = w_launch;
    assign bus.avm_address  = w_launch ? (BASE_ADDR + w_offset) : '0;
    assign bus.weight_valid = (r_count != '0);
    assign bus.weight_data  = (r_count != '0) ? r_mem[r_rd_ptr] : 32'd0;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_index     <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        if (bus.word_count != 14'd0) begin
                            r_index     <= bus.start_index;
                            r_remaining <= bus.word_count;
                            r_busy      <= 1'b1;
                            r_state     <= c_ISSUE;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                c_ISSUE: begin
                    if (w_accept) begin
                        r_index     <= r_index + 13'd1;
                        r_remaining <= r_remaining - 14'd1;
                        if (r_remaining == 14'd1) begin
                            r_state <= c_DRAIN;
                        end
                    end
                end
                c_DRAIN: begin
                    if ((r_pending == 4'd0) && (r_count == '0)) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_pending <= r_pending + 4'd1;
                2'b01:   r_pending <= r_pending - 4'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the read side is gated by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.avm_readdata;
        end
    end
endmodule
`default_nettype wire

// File: doc/weight_fetch_master.md
Name: weight_fetch_master

Overview:
Avalon-MM read master that streams network weights out of on-chip/SDRAM weight memory on behalf of the classifier datapath. Software (via the weight index PIO) or the datapath supplies a start index and word count. The block issues pipelined reads, buffers the returned words in a small FIFO, and presents them on a valid/ready stream to the MAC pipeline. It is the initiator-side counterpart of the existing PIO-style responders on the system interconnect.

Parameters:
ADDR_W, 32, width of the Avalon master byte address.
BASE_ADDR, 32'h0000_0000, byte address of weight word 0.
MAX_PENDING, 4, maximum outstanding read transactions (1..15).
FIFO_DEPTH, 8, output FIFO depth in words; power of 2 and >= MAX_PENDING.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begin a fetch run (honoured only in IDLE)
start_index  in  13  first weight index of the run
word_count  in  14  number of words to fetch (0..8192)
busy  out  1  high from accepted start until the last word leaves the FIFO
done  out  1  single-cycle pulse at end of run
avm_address  out  ADDR_W  read byte address
avm_read  out  1  read request
avm_waitrequest  in  1  interconnect stall
avm_readdata  in  32  returned word
avm_readdatavalid  in  1  returned word valid
weight_data  out  32  stream data (FIFO head)
weight_valid  out  1  stream valid
weight_ready  in  1  stream consumer ready

Behaviour:
- Reset values: busy=0, done=0, avm_read=0, avm_address=0, weight_valid=0, weight_data=0. FIFO and pending counter are empty/zero; state is IDLE.
- States:
  - IDLE: on start with word_count!=0, latch index=start_index and remaining=word_count, then go to ISSUE. On start with word_count==0, pulse done the next cycle and stay in IDLE. busy stays 0.
  - ISSUE: a request may launch when remaining!=0, pending<MAX_PENDING and pending+fifo_count<FIFO_DEPTH (credit rule; the FIFO can never overflow). Then:
    - avm_read=1 and avm_address=BASE_ADDR+{index,2'b00}. Address and read are held stable while avm_waitrequest=1.
    - When read=1 and waitrequest=0, the request is accepted: index+1 (13-bit wrap, 8191->0), remaining-1, pending+1.
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until pending==0 and the FIFO is empty. Then pulse done for 1 cycle, drop busy in the same cycle, and return to IDLE.
- Responses: avm_readdatavalid pushes avm_readdata into the FIFO and decrements pending. If acceptance and readdatavalid occur in the same cycle, pending is unchanged. A readdatavalid with pending==0 is dropped.
- Stream: weight_valid = FIFO not empty; weight_data = FIFO head, first-word fall-through. A pop occurs on valid&&ready. Push and pop in the same cycle is legal, including at full. Order is preserved.
- Latency: start to first avm_read = 1 cycle. Readdatavalid to weight_valid = 1 cycle (registered FIFO write).
- start while busy is ignored; latched parameters are not disturbed.
- Reset mid-run clears all state. Responses arriving after reset are dropped by the pending==0 rule.
- Sustained throughput is 1 word/cycle when waitrequest=0, memory latency <= MAX_PENDING, and weight_ready=1.

Test Plan:
1. start_index=10, word_count=4, waitrequest=0, 2-cycle memory latency, ready=1:
   - addresses 0x28,0x2C,0x30,0x34 in consecutive cycles;
   - 4 words out in order;
   - done 1 pulse; busy low same cycle.
2. waitrequest high for 3 cycles on the 2nd request -> avm_address stays 0x2C and read stays high for 4 cycles; no index skip or duplicate.
3. weight_ready=0 throughout, word_count=20, FIFO_DEPTH=8:
   - exactly 8 requests issued, then avm_read stays low;
   - raising ready resumes issue;
   - all 20 words are delivered with no loss.
4. start_index=8190, word_count=3 -> addresses BASE+0x7FF8, 0x7FFC, 0x0000.
5. word_count=0 -> done pulse 1 cycle after start; no avm_read; busy stays 0. A second start during an active run is ignored and the run completes with its original count.
6. Assert reset with 3 reads pending:
   - all outputs take reset values;
   - late readdatavalid pulses do not appear on the stream;
   - a new run then completes normally.
